// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the score display path: the binary score width,
// the conversion FSM state encoding, active-low seven-segment patterns
// ({g,f,e,d,c,b,a}, 0 = segment lit) and the all-anodes-off constant.
// Also provides seg_decode(), which maps a BCD nibble to its segment pattern.
package game_pkg;

  localparam int SCORE_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Nibbles 10-15 never come out of a correct conversion; they go dark
  // rather than showing a misleading glyph.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble converter: one shift-add-3 step per clock.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   bin    - binary value, sampled when start is seen in IDLE
//   start  - request to begin a conversion (ignored unless IDLE)
//   busy   - high from the cycle after start until the result is handed off
//   bcd    - 4 BCD digits, valid while done is high
//   done   - one-cycle strobe marking the hand-off cycle
module bin2bcd_seq #(
  parameter int SCORE_W = game_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] bin,
  input  logic               start,
  output logic               busy,
  output logic [15:0]        bcd,
  output logic               done
);
  import game_pkg::*;

  localparam int BCD_W = 16;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   adj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The register holds {BCD field, binary field}; each CONVERT cycle
  // corrects any nibble >= 5 and then shifts the binary MSB into the BCD field.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    adj     = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        for (int i = 0; i < BCD_W / 4; i++) begin
          if (adj[SCORE_W + 4*i +: 4] >= 4'd5) begin
            adj[SCORE_W + 4*i +: 4] = adj[SCORE_W + 4*i +: 4] + 4'd3;
          end
        end
        shift_d = {adj[SR_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = shift_q[SCORE_W +: BCD_W];

endmodule

// File: rtl/score_display.sv
// score_display
// Converts the game score to BCD on a load strobe and scans it onto a
// 4-digit multiplexed seven-segment display (segments and anodes active-low).
// Ports:
//   clk      - system clock
//   reset    - asynchronous, active-low reset
//   score_in - binary score from the score counter
//   load     - single-cycle request to sample score_in (ignored while busy)
//   busy     - conversion in progress
//   seg      - segment drive {g,f,e,d,c,b,a}, active-low
//   an       - anode select, active-low, an[0] = ones digit
//   dp       - decimal point, active-low, always off
// Build option: define SCORE_DISPLAY_BLANK_EN to blank leading zeros
// (ones digit always shown). Default build shows all four digits.
module score_display #(
  parameter int SCORE_W     = game_pkg::SCORE_W,
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               load,
  output logic               busy,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  an,
  output logic               dp
);
  import game_pkg::*;

  localparam int RCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SEL_W  = $clog2(DIGITS);

  logic [15:0]        conv_bcd;
  logic               conv_done;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (score_in),
    .start (load),
    .busy  (busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      rcnt_q <= '0;
      sel_q  <= '0;
      an_q   <= AN_OFF & ~4'b0001;
      seg_q  <= SEG_0;
    end else begin
      disp_q <= disp_d;
      rcnt_q <= rcnt_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  // The display value only moves on the converter's hand-off strobe, so the
  // segments never show a half-converted number. Anode/segment registers are
  // fed from the next-state digit select so they stay aligned with it.
  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    rcnt_d = rcnt_q + RCNT_W'(1);
    sel_d  = sel_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      sel_d  = sel_q + SEL_W'(1);
    end
    an_d = AN_OFF & ~(DIGITS'(1) << sel_d);
`ifdef SCORE_DISPLAY_BLANK_EN
    begin
      logic all_zero;
      logic blank;
      all_zero = 1'b1;
      blank    = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        all_zero = all_zero & (disp_d[4*i +: 4] == 4'd0);
        if ((int'(sel_d) == i) && all_zero) begin
          blank = 1'b1;
        end
      end
      seg_d = blank ? SEG_BLANK : seg_decode(disp_d[{sel_d, 2'b00} +: 4]);
    end
`else
    seg_d = seg_decode(disp_d[{sel_d, 2'b00} +: 4]);
`endif
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display
// Directed bench for score_display with a short refresh period. A table of
// scores with hand-computed segment patterns is loaded one by one, then a
// few hand-written sequences cover the timing corner cases.
module tb_score_display;

  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] score_in = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int failures = 0;

  // Segment expectations are packed {digit3, digit2, digit1, digit0}.
  typedef struct {
    logic [12:0] score;
    logic [27:0] seg_plain;
    logic [27:0] seg_blank;
  } vec_t;

  vec_t vecs [7];

  score_display #(
    .SCORE_W     (13),
    .REFRESH_DIV (REFRESH_DIV),
    .DIGITS      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .score_in (score_in),
    .load     (load),
    .busy     (busy),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // One comparison; every failure prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
    end
  endtask

  // Present a value with a one-cycle load pulse; returns at the first
  // falling edge after the sampling edge.
  task automatic applyStimulus(input logic [12:0] value);
    @(negedge clk);
    score_in = value;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Count falling edges on which busy is still high, with a timeout.
  task automatic waitIdle(input string name, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 40) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_busy_timeout actual=stuck_high expected=low", name);
    end
  endtask

  // Follow the scan to each anode in turn and compare the segment pattern.
  task automatic checkDigits(input string name, input logic [27:0] expected);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] target;
      int n;
      target = 4'b1111 & ~(4'b0001 << k);
      n = 0;
      while (an !== target && n < 24) begin
        n++;
        @(negedge clk);
      end
      if (n >= 24) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_scan%0d actual=an_%b expected=an_%b", name, k, an, target);
      end else begin
        checkOutput($sformatf("%s_seg%0d", name, k), {9'b0, seg}, {9'b0, expected[7*k +: 7]});
      end
    end
  endtask

  function automatic logic [27:0] pickSeg(input logic [27:0] plain, input logic [27:0] blank);
`ifdef SCORE_DISPLAY_BLANK_EN
    return blank;
`else
    return plain;
`endif
  endfunction

  initial begin
    int cyc;
    int low;

    vecs[0] = '{score: 13'd1234, seg_plain: {S1, S2, S3, S4}, seg_blank: {S1, S2, S3, S4}};
    vecs[1] = '{score: 13'd8191, seg_plain: {S8, S1, S9, S1}, seg_blank: {S8, S1, S9, S1}};
    vecs[2] = '{score: 13'd0,    seg_plain: {S0, S0, S0, S0}, seg_blank: {SB, SB, SB, S0}};
    vecs[3] = '{score: 13'd7,    seg_plain: {S0, S0, S0, S7}, seg_blank: {SB, SB, SB, S7}};
    vecs[4] = '{score: 13'd42,   seg_plain: {S0, S0, S4, S2}, seg_blank: {SB, SB, S4, S2}};
    vecs[5] = '{score: 13'd1000, seg_plain: {S1, S0, S0, S0}, seg_blank: {S1, S0, S0, S0}};
    vecs[6] = '{score: 13'd905,  seg_plain: {S0, S9, S0, S5}, seg_blank: {SB, S9, S0, S5}};

    // Reset values while held, then the anode scan after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_an",   {12'b0, an},  16'b1110);
    checkOutput("rst_seg",  {9'b0, seg},  {9'b0, S0});
    checkOutput("rst_busy", {15'b0, busy}, 16'b0);
    checkOutput("rst_dp",   {15'b0, dp},  16'b1);
    reset = 1'b1;
    checkOutput("scan_an0", {12'b0, an}, 16'b1110);
    for (int k = 1; k <= 4; k++) begin
      repeat (REFRESH_DIV) @(negedge clk);
      checkOutput($sformatf("scan_step%0d", k), {12'b0, an},
                  {12'b0, 4'b1111 & ~(4'b0001 << (k % 4))});
    end

    // Table of scores: busy length and decoded digits.
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d_%0d", i, vecs[i].score);
      applyStimulus(vecs[i].score);
      checkOutput({tag, "_busy_rise"}, {15'b0, busy}, 16'b1);
      waitIdle(tag, cyc);
      checkOutput({tag, "_busy_len"}, 16'(cyc), 16'd14);
      checkDigits(tag, pickSeg(vecs[i].seg_plain, vecs[i].seg_blank));
      checkOutput({tag, "_dp"}, {15'b0, dp}, 16'b1);
    end

    // A load during busy is dropped; the first value finishes unchanged.
    applyStimulus(13'd1234);
    repeat (4) @(negedge clk);
    score_in = 13'd5678;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    waitIdle("ignored", cyc);
    checkOutput("ignored_busy_len", 16'(cyc), 16'd9);
    repeat (2) @(negedge clk);
    checkOutput("ignored_no_restart", {15'b0, busy}, 16'b0);
    checkDigits("ignored", {S1, S2, S3, S4});

    // Reset part-way through a conversion.
    applyStimulus(13'd4321);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {15'b0, busy}, 16'b0);
    checkOutput("midrst_an",   {12'b0, an},   16'b1110);
    checkOutput("midrst_seg",  {9'b0, seg},   {9'b0, S0});
    @(negedge clk);
    reset = 1'b1;
    checkDigits("midrst", pickSeg({S0, S0, S0, S0}, {SB, SB, SB, S0}));
    checkOutput("midrst_idle", {15'b0, busy}, 16'b0);
    applyStimulus(13'd42);
    waitIdle("after_rst", cyc);
    checkDigits("after_rst", pickSeg({S0, S0, S4, S2}, {SB, SB, S4, S2}));

    // Load held high: exactly one idle cycle between back-to-back conversions.
    @(negedge clk);
    score_in = 13'd1000;
    load     = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    score_in = 13'd6;
    waitIdle("held_first", cyc);
    checkOutput("held_first_len", 16'(cyc), 16'd11);
    low = 0;
    while (busy === 1'b0 && low < 10) begin
      low++;
      @(negedge clk);
    end
    load = 1'b0;
    checkOutput("held_gap", 16'(low), 16'd1);
    waitIdle("held_second", cyc);
    checkOutput("held_second_len", 16'(cyc), 16'd14);
    checkDigits("held", pickSeg({S0, S0, S0, S6}, {SB, SB, SB, S6}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the game's running score counter.
- Samples the 13-bit binary score on a load strobe and converts it to 4 BCD digits with a sequential double-dabble engine.
- Drives the board's 4-digit multiplexed seven-segment display (segments and anodes active-low).
- Sits between the score counter and the top-level display pins.

Parameters:
- SCORE_W, 13, width of binary score input (max value 8191 fits 4 BCD digits)
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2
- DIGITS, 4, number of display digits (fixed at 4; not intended for override)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- score_in  in  SCORE_W  binary score from the score counter
- load  in  1  single-cycle request to sample score_in and start conversion
- busy  out  1  high while conversion in progress; load ignored while high
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low
- an  out  4  anode select, active-low, an[0] = rightmost (ones) digit
- dp  out  1  decimal point, active-low; held 1 (off)

Behaviour:
- Reset (reset=0, async): FSM=IDLE, shift reg=0, bit count=0, displayed BCD=0x0000, refresh count=0, digit_sel=0, busy=0, an=4'b1110, seg=7'b1000000 ("0"), dp=1.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - load=1 → latch score_in into the shift register, clear the BCD field and bit count, go to CONVERT.
  - busy rises on the next edge.
- CONVERT: one bit per cycle, SCORE_W cycles.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1.
  - After the SCORE_W-th shift, go to DONE.
- DONE:
  - Copy the 4 BCD nibbles into the display register, go to IDLE.
  - busy falls on the same edge.
- Latency: load sampled at edge N → display register updated at edge N+SCORE_W+1 (N+14 by default). busy is high for edges N+1 through N+14.
- load while busy=1: ignored, no queuing; the in-flight conversion completes unchanged.
- load held high continuously: a new conversion starts on the first IDLE cycle after DONE.
- Display register changes only in DONE, so there is no partial-value glitch on the segments during conversion.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_sel increments mod 4 (3 → 0).
  - Runs independently of the FSM.
- Outputs are registered: an = ~(1<<digit_sel); seg = pattern of display nibble [digit_sel].
- Segment patterns for 0-9 are standard. Nibbles 10-15 cannot occur and map to all-off (7'b1111111).
- Reset mid-conversion: conversion aborted, display returns to "0000" immediately, busy=0.

Optional Feature:
- Macro: SCORE_DISPLAY_BLANK_EN.
- Defined: leading-zero blanking.
  - A digit is blanked (seg=7'b1111111, anode still scanned) when it and every more-significant digit are 0.
  - The ones digit is never blanked, so score 0 shows "   0".
- Undefined: all 4 digits always shown, e.g. score 7 shows "0007".

Decomposition:
- Shared package game_pkg:
  - SCORE_W
  - state enum {IDLE, CONVERT, DONE}
  - segment constants SEG_0..SEG_9 and SEG_BLANK
  - anode idle constant AN_OFF=4'b1111
- Sub-module bin2bcd_seq:
  - Contains the FSM and shift-add-3 datapath.
  - Ports: clk, reset, bin, start, busy, bcd[15:0], done.
  - score_display keeps the refresh counter, mux and segment decode.

Test Plan (sim with REFRESH_DIV=4):
- Reset: hold reset=0, then release → an=1110, seg=1000000, busy=0. With the feature off, an cycles 1110→1101→1011→0111 every 4 clks.
- Load 1234 → busy=1 for exactly 14 clks. Display then shows 4,3,2,1 on an[0..3]: seg 0011001, 0110000, 0100100, 1111001.
- Load 8191 (max) → digits 1,9,1,8. Then load 0 → "0000" (feature off) or only an[0] lit with "0" (feature on).
- Load 1234, pulse load with score_in=5678 at the 5th busy clk → second load ignored, final display 1234.
- Load 4321, assert reset at the 7th convert clk → outputs return to reset values. After release, load 0042 → display 0042, or "  42" with SCORE_DISPLAY_BLANK_EN.
- Load 7 with SCORE_DISPLAY_BLANK_EN → digits 3,2,1 seg=1111111, digit 0 seg=1111000.
